// File: rtl/i2s_tx_buffered.sv
// i2s_tx_buffered: FIFO-buffered Philips I2S transmitter.
// Stereo sample pairs are queued in a small FIFO and shifted out MSB-first
// in 64-BCK frames (32-bit slots, DATA_BITS payload left-justified in each slot).
module i2s_tx_buffered #(
  parameter int DATA_BITS    = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int BCK_HALF_DIV = 4
) (
  input  logic                              AMCLK_i,
  input  logic                              nARST,
  input  logic signed [DATA_BITS-1:0]       APSDATA_LEFT_i,
  input  logic signed [DATA_BITS-1:0]       APSDATA_RIGHT_i,
  input  logic                              APDATA_VALID_i,
  input  logic                              CLR_FLAGS_i,
  output logic                              I2S_BCK,
  output logic                              I2S_WS,
  output logic                              I2S_DATA,
  output logic [$clog2(FIFO_DEPTH):0]       FIFO_LEVEL_o,
  output logic                              OVERFLOW_o,
  output logic                              UNDERRUN_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BCK_HALF_DIV);
  localparam logic [CW-1:0] DIV_TC = CW'(BCK_HALF_DIV - 1);

  // Bit-clock generation and slot tracking
  logic [CW-1:0] div_q, div_d;
  logic          bck_q, bck_d;
  logic [5:0]    slot_q, slot_d;
  logic          ws_q, ws_d;
  logic          data_q, data_d;

  // Sample currently being transmitted
  logic signed [DATA_BITS-1:0] hold_l_q, hold_l_d;
  logic signed [DATA_BITS-1:0] hold_r_q, hold_r_d;

  // FIFO storage and control
  logic signed [DATA_BITS-1:0] mem_l_q [FIFO_DEPTH];
  logic signed [DATA_BITS-1:0] mem_r_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          und_q, und_d;

  logic          shift_edge;
  logic          load_edge;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          und_set;
  logic [5:0]    slot_next;

  // Returns the bit of smp that belongs at position pos (0 = MSB) of a slot;
  // positions past the sample width are padding and read as 0.
  function automatic logic slot_bit(input logic signed [DATA_BITS-1:0] smp,
                                    input logic [4:0] pos);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (int'(pos) == DATA_BITS - 1 - i) b = smp[i];
    end
    return b;
  endfunction

  assign shift_edge = (div_q == DIV_TC) && bck_q;
  assign load_edge  = shift_edge && (slot_q == 6'd62);
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // Pop is resolved before push, so a full FIFO still accepts a push on a pop cycle.
  assign pop        = load_edge && !fifo_empty;
  assign push       = APDATA_VALID_i && (!fifo_full || pop);
  assign ovf_set    = APDATA_VALID_i && fifo_full && !pop;
  assign und_set    = load_edge && fifo_empty;
  assign slot_next  = slot_q + 6'd1;

  // Next-state for bit clock, slot counter, serial outputs and held pair
  always_comb begin
    div_d    = (div_q == DIV_TC) ? '0 : div_q + CW'(1);
    bck_d    = (div_q == DIV_TC) ? ~bck_q : bck_q;
    slot_d   = slot_q;
    ws_d     = ws_q;
    data_d   = data_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (shift_edge) begin
      slot_d = slot_next;
      ws_d   = (slot_next >= 6'd31) && (slot_next <= 6'd62);
      data_d = slot_next[5] ? slot_bit(hold_r_q, slot_next[4:0])
                            : slot_bit(hold_l_q, slot_next[4:0]);
    end
    // On underrun the previous pair is simply kept and re-sent.
    if (pop) begin
      hold_l_d = mem_l_q[rptr_q[AW-1:0]];
      hold_r_d = mem_r_q[rptr_q[AW-1:0]];
    end
  end

  // Next-state for FIFO pointers, level and sticky flags
  always_comb begin
    wptr_d  = wptr_q + {{AW{1'b0}}, push};
    rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    level_d = wptr_d - rptr_d;
    ovf_d   = ovf_set ? 1'b1 : (CLR_FLAGS_i ? 1'b0 : ovf_q);
    und_d   = und_set ? 1'b1 : (CLR_FLAGS_i ? 1'b0 : und_q);
  end

  // Serializer state; reset aborts any frame in flight and restarts at slot 63
  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      div_q    <= '0;
      bck_q    <= 1'b0;
      slot_q   <= 6'd63;
      ws_q     <= 1'b0;
      data_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else begin
      div_q    <= div_d;
      bck_q    <= bck_d;
      slot_q   <= slot_d;
      ws_q     <= ws_d;
      data_q   <= data_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end

  // FIFO control and flags; reset flushes the queue immediately
  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
    end
  end

  // FIFO storage write; contents are only meaningful between the pointers
  always_ff @(posedge AMCLK_i) begin
    if (push) begin
      mem_l_q[wptr_q[AW-1:0]] <= APSDATA_LEFT_i;
      mem_r_q[wptr_q[AW-1:0]] <= APSDATA_RIGHT_i;
    end
  end

  assign I2S_BCK      = bck_q;
  assign I2S_WS       = ws_q;
  assign I2S_DATA     = data_q;
  assign FIFO_LEVEL_o = level_q;
  assign OVERFLOW_o   = ovf_q;
  assign UNDERRUN_o   = und_q;

endmodule
